exe_forward_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, plus its forwarding unit and the EXE/MEM pipeline register.
- Takes ID/EXE register contents and resolves RAW hazards by forwarding from the MEM or WB stage.
- Computes the ALU result and resolves branches; branch outputs go back to IF.
- Registers the result, store value, control bits and destination into the EXE/MEM register.

---
 rtl/exe_pkg.sv | 30 +++
 rtl/exe_forward_stage_if.sv | 47 ++++
 rtl/exe_fwd_unit.sv | 48 ++++
 rtl/exe_forward_stage.sv | 123 ++++++++++++
 tb/tb_exe_forward_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the MIPS execute stage: ALU commands, branch types and
// forwarding-select values.
package exe_pkg;

    typedef enum logic [3:0] {
        EXE_ADD = 4'b0000,
        EXE_SUB = 4'b0010,
        EXE_AND = 4'b0100,
        EXE_OR  = 4'b0101,
        EXE_NOR = 4'b0110,
        EXE_XOR = 4'b0111,
        EXE_SLL = 4'b1000,
        EXE_SRA = 4'b1001,
        EXE_SRL = 4'b1010
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/exe_forward_stage_if.sv
// ID/EXE inputs, WB feedback, branch outputs and EXE/MEM register outputs of
// the execute stage, bundled with master (driver) and slave (stage) views.
interface exe_forward_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] pc;
    logic [1:0]        br_type;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_wb_en;
    logic [REG_AW-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              br_taken;
    logic [DATA_W-1:0] br_addr;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [1:0]        st_sel;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_st_val;
    logic [REG_AW-1:0] mem_dest;

    modport master (
        output exe_cmd, val1, val2, reg2, pc, br_type, src1, src2, dest,
               wb_en_in, mem_r_en_in, mem_w_en_in, wb_wb_en, wb_dest, wb_value,
        input  br_taken, br_addr, fwd_a_sel, fwd_b_sel, st_sel,
               mem_wb_en, mem_r_en, mem_w_en, mem_alu_result, mem_st_val, mem_dest
    );

    modport slave (
        input  exe_cmd, val1, val2, reg2, pc, br_type, src1, src2, dest,
               wb_en_in, mem_r_en_in, mem_w_en_in, wb_wb_en, wb_dest, wb_value,
        output br_taken, br_addr, fwd_a_sel, fwd_b_sel, st_sel,
               mem_wb_en, mem_r_en, mem_w_en, mem_alu_result, mem_st_val, mem_dest
    );
endinterface

// File: rtl/exe_fwd_unit.sv
// Combinational RAW-hazard forwarding selects for the execute stage.
// Active only when FORWARDING_EN is defined; otherwise all selects are FWD_NONE.
module exe_fwd_unit
    import exe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              mem_w_en_in,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              wb_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    output fwd_sel_e          fwd_a_sel,
    output fwd_sel_e          fwd_b_sel,
    output fwd_sel_e          st_sel
);
`ifdef FORWARDING_EN
    // The younger result in EXE/MEM wins over the older one in WB; r0 never forwards.
    function automatic fwd_sel_e pick(
        input logic [REG_AW-1:0] src,
        input logic              m_en,
        input logic [REG_AW-1:0] m_dest,
        input logic              w_en,
        input logic [REG_AW-1:0] w_dest
    );
        if (m_en && (m_dest != '0) && (m_dest == src))
            return FWD_MEM;
        else if (w_en && (w_dest != '0) && (w_dest == src))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

    assign fwd_a_sel = pick(src1, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    assign st_sel    = pick(src2, mem_wb_en, mem_dest, wb_wb_en, wb_dest);
    // A store's val2 is the address offset, so only its data path may forward.
    assign fwd_b_sel = mem_w_en_in ? FWD_NONE : st_sel;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{src1, src2, mem_w_en_in, mem_wb_en, mem_dest,
                                 wb_wb_en, wb_dest};
    assign fwd_a_sel = FWD_NONE;
    assign fwd_b_sel = FWD_NONE;
    assign st_sel    = FWD_NONE;
`endif
endmodule

// File: rtl/exe_forward_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolution and EXE/MEM
// register. Forwarding is compiled in with FORWARDING_EN.
module exe_forward_stage
    import exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic                clk,
    input logic                rst,
    exe_forward_stage_if.slave bus
);
    fwd_sel_e                 fwd_a_sel_p0;
    fwd_sel_e                 fwd_b_sel_p0;
    fwd_sel_e                 st_sel_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic signed [DATA_W-1:0] s_p0;
    logic signed [DATA_W-1:0] alu_p0;
    logic                     br_taken_p0;

    logic                     wb_en_p1;
    logic                     mem_r_en_p1;
    logic                     mem_w_en_p1;
    logic signed [DATA_W-1:0] alu_p1;
    logic signed [DATA_W-1:0] st_val_p1;
    logic [REG_AW-1:0]        dest_p1;

    function automatic logic signed [DATA_W-1:0] fwd_mux(
        input fwd_sel_e                 sel,
        input logic signed [DATA_W-1:0] orig,
        input logic signed [DATA_W-1:0] mem_val,
        input logic signed [DATA_W-1:0] wb_val
    );
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return orig;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] alu_op(
        input logic [3:0]               cmd,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (cmd)
            EXE_ADD: return a + b;
            EXE_SUB: return a - b;
            EXE_AND: return a & b;
            EXE_OR:  return a | b;
            EXE_NOR: return ~(a | b);
            EXE_XOR: return a ^ b;
            EXE_SLL: return a << sh;
            EXE_SRA: return a >>> sh;
            EXE_SRL: return $signed($unsigned(a) >> sh);
            default: return '0;
        endcase
    endfunction

    // ---- stage p0: forwarding, ALU, branch (combinational) ----
    exe_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .src1        (bus.src1),
        .src2        (bus.src2),
        .mem_w_en_in (bus.mem_w_en_in),
        .mem_wb_en   (wb_en_p1),
        .mem_dest    (dest_p1),
        .wb_wb_en    (bus.wb_wb_en),
        .wb_dest     (bus.wb_dest),
        .fwd_a_sel   (fwd_a_sel_p0),
        .fwd_b_sel   (fwd_b_sel_p0),
        .st_sel      (st_sel_p0)
    );

    assign a_p0   = fwd_mux(fwd_a_sel_p0, bus.val1, alu_p1, bus.wb_value);
    assign b_p0   = fwd_mux(fwd_b_sel_p0, bus.val2, alu_p1, bus.wb_value);
    assign s_p0   = fwd_mux(st_sel_p0,    bus.reg2, alu_p1, bus.wb_value);
    assign alu_p0 = alu_op(bus.exe_cmd, a_p0, b_p0);

    always_comb begin
        br_taken_p0 = 1'b0;
        case (bus.br_type)
            BR_BEZ:  br_taken_p0 = (a_p0 == '0);
            BR_BNE:  br_taken_p0 = (a_p0 != s_p0);
            BR_JMP:  br_taken_p0 = 1'b1;
            default: br_taken_p0 = 1'b0;
        endcase
    end

    assign bus.br_taken  = br_taken_p0;
    assign bus.br_addr   = bus.pc + (bus.val2 << 2);
    assign bus.fwd_a_sel = fwd_a_sel_p0;
    assign bus.fwd_b_sel = fwd_b_sel_p0;
    assign bus.st_sel    = st_sel_p0;

    // ---- stage p1: EXE/MEM register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_p1    <= 1'b0;
            mem_r_en_p1 <= 1'b0;
            mem_w_en_p1 <= 1'b0;
            alu_p1      <= '0;
            st_val_p1   <= '0;
            dest_p1     <= '0;
        end else begin
            wb_en_p1    <= bus.wb_en_in;
            mem_r_en_p1 <= bus.mem_r_en_in;
            mem_w_en_p1 <= bus.mem_w_en_in;
            alu_p1      <= alu_p0;
            st_val_p1   <= s_p0;
            dest_p1     <= bus.dest;
        end
    end

    assign bus.mem_wb_en      = wb_en_p1;
    assign bus.mem_r_en       = mem_r_en_p1;
    assign bus.mem_w_en       = mem_w_en_p1;
    assign bus.mem_alu_result = alu_p1;
    assign bus.mem_st_val     = st_val_p1;
    assign bus.mem_dest       = dest_p1;
endmodule

// File: tb/tb_exe_forward_stage.sv
// Directed bench for exe_forward_stage; expectations follow FORWARDING_EN.
module tb_exe_forward_stage;
    import exe_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    exe_forward_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    exe_forward_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic wb);
        bus.exe_cmd = cmd; bus.val1 = v1; bus.val2 = v2;
        bus.src1 = s1; bus.src2 = s2; bus.dest = d; bus.wb_en_in = wb;
    endtask

    initial begin
        rst = 1'b0;
        bus.exe_cmd = '0; bus.val1 = '0; bus.val2 = '0; bus.reg2 = '0; bus.pc = '0;
        bus.br_type = '0; bus.src1 = '0; bus.src2 = '0; bus.dest = '0;
        bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0;
        bus.wb_wb_en = 0; bus.wb_dest = '0; bus.wb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu", bus.mem_alu_result, 32'h0);
        check("rst_dest", {27'b0, bus.mem_dest}, 32'h0);
        check("rst_wb_en", {31'b0, bus.mem_wb_en}, 32'h0);
        rst = 1'b1;

        // ADD r3 = 3 + 4
        instr(EXE_ADD, 32'd3, 32'd4, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        check("add_res", bus.mem_alu_result, 32'd7);
        check("add_dest", {27'b0, bus.mem_dest}, 32'd3);
        check("add_wb_en", {31'b0, bus.mem_wb_en}, 32'd1);

        // dependent SUB on r3
        instr(EXE_SUB, 32'd0, 32'd2, 5'd3, 5'd0, 5'd7, 1'b1);
        #1;
        check("sub_fwd_a", {30'b0, bus.fwd_a_sel}, FWD ? 32'd1 : 32'd0);
        tick();
        check("sub_res", bus.mem_alu_result, FWD ? 32'd5 : 32'hFFFF_FFFE);

        // put r6 in EXE/MEM, then forward r4 from WB
        instr(EXE_ADD, 32'h10, 32'h0, 5'd0, 5'd0, 5'd6, 1'b1);
        tick();
        check("mem6_dest", {27'b0, bus.mem_dest}, 32'd6);
        instr(EXE_ADD, 32'h100, 32'd1, 5'd0, 5'd4, 5'd4, 1'b1);
        bus.wb_wb_en = 1'b1; bus.wb_dest = 5'd4; bus.wb_value = 32'd9;
        #1;
        check("wb_fwd_b", {30'b0, bus.fwd_b_sel}, FWD ? 32'd2 : 32'd0);
        tick();
        check("wb_fwd_res", bus.mem_alu_result, FWD ? 32'h109 : 32'h101);

        // MEM and WB both hold r4: MEM wins
        instr(EXE_OR, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0, 1'b0);
        #1;
        check("prio_fwd_b", {30'b0, bus.fwd_b_sel}, FWD ? 32'd1 : 32'd0);
        check("prio_st", {30'b0, bus.st_sel}, FWD ? 32'd1 : 32'd0);
        tick();
        check("prio_res", bus.mem_alu_result, FWD ? 32'h109 : 32'h0);
        bus.wb_wb_en = 1'b0;

        // store whose data register r5 sits in EXE/MEM
        instr(EXE_ADD, 32'h20, 32'h0, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        check("r5_res", bus.mem_alu_result, 32'h20);
        instr(EXE_ADD, 32'h100, 32'd8, 5'd0, 5'd5, 5'd0, 1'b0);
        bus.mem_w_en_in = 1'b1; bus.reg2 = 32'd1;
        #1;
        check("st_fwd_b", {30'b0, bus.fwd_b_sel}, 32'd0);
        check("st_sel", {30'b0, bus.st_sel}, FWD ? 32'd1 : 32'd0);
        tick();
        check("st_val", bus.mem_st_val, FWD ? 32'h20 : 32'h1);
        check("st_addr", bus.mem_alu_result, 32'h108);
        check("st_w_en", {31'b0, bus.mem_w_en}, 32'd1);
        bus.mem_w_en_in = 1'b0;

        // branches (EXE/MEM now holds no writer)
        instr(EXE_ADD, 32'h0, 32'd3, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.pc = 32'h10; bus.br_type = BR_BEZ;
        #1;
        check("bez_taken", {31'b0, bus.br_taken}, 32'd1);
        check("bez_addr", bus.br_addr, 32'h1C);
        bus.val1 = 32'd5;
        #1;
        check("bez_not", {31'b0, bus.br_taken}, 32'd0);
        bus.br_type = BR_BNE; bus.val1 = 32'h55; bus.reg2 = 32'h55;
        #1;
        check("bne_eq", {31'b0, bus.br_taken}, 32'd0);
        bus.reg2 = 32'h56;
        #1;
        check("bne_ne", {31'b0, bus.br_taken}, 32'd1);
        bus.br_type = BR_JMP;
        #1;
        check("jmp", {31'b0, bus.br_taken}, 32'd1);
        bus.br_type = BR_NONE;
        #1;
        check("none", {31'b0, bus.br_taken}, 32'd0);

        // r0 in EXE/MEM and WB must not forward
        instr(EXE_ADD, 32'h77, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        instr(EXE_ADD, 32'h3, 32'd1, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.wb_wb_en = 1'b1; bus.wb_dest = 5'd0; bus.wb_value = 32'hDEAD;
        #1;
        check("r0_fwd_a", {30'b0, bus.fwd_a_sel}, 32'd0);
        tick();
        check("r0_res", bus.mem_alu_result, 32'd4);
        bus.wb_wb_en = 1'b0;

        // ALU operations
        instr(EXE_SRA, 32'h8000_0000, 32'd4, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("sra", bus.mem_alu_result, 32'hF800_0000);
        bus.exe_cmd = EXE_SRL;
        tick();
        check("srl", bus.mem_alu_result, 32'h0800_0000);
        instr(EXE_SLL, 32'd3, 32'h24, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("sll", bus.mem_alu_result, 32'h30);
        instr(EXE_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("nor", bus.mem_alu_result, 32'hF0F0_FF00);
        instr(EXE_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("xor", bus.mem_alu_result, 32'hF0F0_F0F0);
        bus.exe_cmd = EXE_AND;
        tick();
        check("and", bus.mem_alu_result, 32'h0F00_0F00);
        bus.exe_cmd = 4'b1111;
        tick();
        check("bad_cmd", bus.mem_alu_result, 32'h0);

        // asynchronous reset mid-run
        instr(EXE_ADD, 32'h11, 32'h0, 5'd0, 5'd0, 5'd9, 1'b1);
        bus.mem_r_en_in = 1'b1;
        tick();
        check("pre_rst_res", bus.mem_alu_result, 32'h11);
        #2 rst = 1'b0;
        #1;
        check("arst_res", bus.mem_alu_result, 32'h0);
        check("arst_wb_en", {31'b0, bus.mem_wb_en}, 32'h0);
        check("arst_r_en", {31'b0, bus.mem_r_en}, 32'h0);
        check("arst_dest", {27'b0, bus.mem_dest}, 32'h0);
        tick();
        check("arst_hold", bus.mem_alu_result, 32'h0);
        rst = 1'b1;
        tick();
        check("post_rst_res", bus.mem_alu_result, 32'h11);
        check("post_rst_dest", {27'b0, bus.mem_dest}, 32'd9);
        check("post_rst_r_en", {31'b0, bus.mem_r_en}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
